cdc_handshake_tx: RTL and testbench
===================================

// Module: cdc_handshake_tx
// PURPOSE
//  Source-side controller for a 4-phase req/ack clock-domain crossing of a DATA_W word.
//  Accepts a word on a valid/ready port and holds it stable on o_data.
//  Raises o_req, then sequences req/ack through both phases.
//  Ack arrives async from the destination domain. It is resynchronised internally
//  by a 1-bit, SYNC_FFS-deep synchronizer instance (ack_s).
//  A timeout watchdog aborts a stalled handshake and flags it.
// PARAMETERS
//  DATA_W    8    width of transferred word
//  SYNC_FFS  2    flop depth of internal ack synchronizer (>=2)
//  TIMEOUT   255  max cycles spent in REQ or REL before abort; 0 = watchdog disabled
// PORTS
//  i_clk          in   1       source-domain clock
//  i_reset_n      in   1       asynchronous, active-low reset
//  i_valid        in   1       upstream word valid
//  o_ready        out  1       controller can accept a word this cycle
//  i_data         in   DATA_W  upstream word
//  o_data         out  DATA_W  captured word, stable from o_req rise until return to IDLE
//  o_req          out  1       handshake request to destination domain (registered)
//  i_ack          in   1       destination ack, asynchronous to i_clk
//  o_busy         out  1       1 when state != IDLE
//  o_done         out  1       1-cycle pulse, handshake completed without abort
//  o_timeout      out  1       sticky flag, watchdog fired
//  i_clr_timeout  in   1       clears o_timeout
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - state=IDLE; o_req=0, o_data=0, o_done=0, o_timeout=0; counter=0; ack_s chain=0.
//  - o_ready is forced 0 while i_reset_n=0.
//  o_ready = (state==IDLE) & ~ack_s & i_reset_n; combinational, never depends on i_valid.
//  States:
//  - IDLE: on i_valid & o_ready, at the same edge: o_data<=i_data, o_req<=1, state->REQ.
//    A stale ack_s=1 blocks acceptance until ack_s=0.
//  - REQ: if ack_s=1: o_req<=0, state->REL.
//    Else if TIMEOUT!=0 and cnt==TIMEOUT-1: o_req<=0, o_timeout<=1, aborted<=1, state->REL.
//  - REL: if ack_s=0: state->IDLE, o_done<=~aborted, aborted<=0.
//    Else if TIMEOUT!=0 and cnt==TIMEOUT-1: o_timeout<=1, aborted<=0, state->IDLE, no o_done.
//  Watchdog counter:
//  - width $clog2(TIMEOUT+1); cleared on every state entry; increments each cycle in REQ/REL.
//  - Saturates; never wraps.
//  Latency:
//  - o_req rises 1 edge after acceptance.
//  - o_req falls 1 edge after ack_s=1; ack_s lags i_ack by SYNC_FFS edges.
//  - o_done pulses 1 edge after ack_s=0; o_ready=1 in the cycle after o_done.
//  - Minimum accept-to-accept interval is 2*SYNC_FFS+3 cycles when ack responds instantly.
//  o_data changes only on acceptance; it holds its value in REQ, REL and IDLE.
//  o_timeout:
//  - set has priority over i_clr_timeout in the same cycle.
//  - Otherwise i_clr_timeout=1 clears it at the next edge.
//  - The flag does not block new transfers.
//  Reset mid-transfer: o_req drops immediately (async) and the word is discarded, with no o_done.
//  The destination must tolerate a truncated req.
//  o_done, o_timeout and o_req are all registered; there are no combinational paths from i_ack.
// TESTING
//  1 Single xfer: i_data=0xA5 with i_valid; dest model asks 2 cycles after seeing o_req.
//    -> o_data=0xA5 held; o_req high; one o_done pulse; o_ready back to 1; o_timeout=0.
//  2 Back-to-back: i_valid held with 0x01 then 0x02.
//    -> exactly two acceptances, in order; o_data 0x01 then 0x02; two o_done pulses;
//       o_ready=0 for the whole of each handshake.
//  3 Timeout: TIMEOUT=16, i_ack tied 0.
//    -> o_req falls 16 cycles after rising; o_timeout=1; no o_done; o_ready=1 next cycle.
//    Then pulse i_clr_timeout -> o_timeout=0.
//  4 Stale ack: i_ack=1 while IDLE and i_valid=1.
//    -> o_ready=0, no accept; drop i_ack -> accept SYNC_FFS+0..1 cycles later.
//  5 Reset in REQ: assert i_reset_n=0 mid-cycle.
//    -> o_req=0 before the next edge; o_busy=0; after release o_ready=1, no o_done.
//  6 Timeout fires in the same cycle as i_clr_timeout=1 -> o_timeout=1 afterwards.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack clock-domain crossing.
// Takes one word from a valid/ready port, holds it on o_data and runs
// req/ack through both phases. A watchdog aborts a handshake that stalls.
// The async ack is resynchronised by a small flop chain before any use.

// Multi-flop synchronizer for a single asynchronous level signal.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the async level through STAGES flops; only the last flop is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

module cdc_handshake_tx #(
    parameter int DATA_W   = 8,
    parameter int SYNC_FFS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_req,
    input  logic              i_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    input  logic              i_clr_timeout
);

    // A zero TIMEOUT disables the watchdog; keep the counter 1 bit wide then.
    localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             aborted;
    logic             ack_s;
    logic             expired;

    // Ack comes from another clock domain, so only its synchronised copy is used.
    cdc_sync_bit #(
        .STAGES (SYNC_FFS)
    ) u_ack_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .d     (i_ack),
        .q     (ack_s)
    );

    // Watchdog fires on the last allowed cycle of REQ or REL.
    assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // A lingering ack from the previous transfer must clear before a new word
    // is taken, otherwise the destination could see a req with ack already high.
    assign o_ready = (state == IDLE) && !ack_s && i_reset_n;
    assign o_busy  = (state != IDLE);

    // Handshake FSM with registered req/done/timeout and the watchdog counter.
    // The timeout clear is written first so a same-cycle set overrides it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            o_req     <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            cnt       <= '0;
            aborted   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_clr_timeout) begin
                o_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_valid && o_ready) begin
                        o_data <= i_data;
                        o_req  <= 1'b1;
                        state  <= REQ;
                    end
                end

                REQ: begin
                    if (ack_s) begin
                        o_req <= 1'b0;
                        cnt   <= '0;
                        state <= REL;
                    end else if (expired) begin
                        o_req     <= 1'b0;
                        o_timeout <= 1'b1;
                        aborted   <= 1'b1;
                        cnt       <= '0;
                        state     <= REL;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REL: begin
                    if (!ack_s) begin
                        o_done  <= ~aborted;
                        aborted <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                        aborted   <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    o_req   <= 1'b0;
                    aborted <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: scoreboard bench for cdc_handshake_tx.
// Stimulus pushes the expected outcome of each word; a monitor pops and
// compares when the DUT accepts a word and when it returns to idle.

module tb_cdc_handshake_tx;

    localparam int DATA_W   = 8;
    localparam int SYNC_FFS = 2;
    localparam int TIMEOUT  = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       done;
        logic       to;
        logic       ready;
        logic       reset_case;
    } exp_t;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;
    logic              o_req;
    logic              i_ack;
    logic              o_busy;
    logic              o_done;
    logic              o_timeout;
    logic              i_clr_timeout;

    int   ack_mode;
    logic auto_ack_q;
    int   ack_wait;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   accepts      = 0;
    int   done_pulses  = 0;
    int   protocol_err = 0;
    exp_t exp_q[$];

    cdc_handshake_tx #(
        .DATA_W   (DATA_W),
        .SYNC_FFS (SYNC_FFS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_data        (o_data),
        .o_req         (o_req),
        .i_ack         (i_ack),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .i_clr_timeout (i_clr_timeout)
    );

    always #5 i_clk = ~i_clk;

    // ack_mode: 0 = held low, 1 = held high, 2 = destination model.
    assign i_ack = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? auto_ack_q : 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void push_exp(input logic [7:0] d, input logic dn, input logic t,
                                     input logic r, input logic rc);
        exp_t e;
        e.data       = d;
        e.done       = dn;
        e.to         = t;
        e.ready      = r;
        e.reset_case = rc;
        exp_q.push_back(e);
    endfunction

    // Called at a negedge; offers a word and returns at the negedge after acceptance.
    task automatic apply_stimulus(input logic [7:0] d, input logic dn, input logic t,
                                  input logic r, input logic rc, input bit keep_valid);
        bit ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        for (int k = 0; k < 40; k++) begin
            if (o_ready) begin
                push_exp(d, dn, t, r, rc);
                ok = 1'b1;
                @(posedge i_clk);
                @(negedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        if (!keep_valid || !ok) begin
            i_valid = 1'b0;
        end
        check_output("word_accepted", ok, 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                idle = 1'b1;
                break;
            end
        end
        check_output({name, "_idle"}, idle, 1);
    endtask

    // Destination model: raises ack two cycles after seeing req, drops it once req falls.
    initial begin
        forever begin
            @(negedge i_clk);
            if (ack_mode != 2) begin
                auto_ack_q = 1'b0;
                ack_wait   = 0;
            end else if (o_req && !auto_ack_q) begin
                ack_wait++;
                if (ack_wait >= 2) begin
                    auto_ack_q = 1'b1;
                end
            end else if (!o_req) begin
                auto_ack_q = 1'b0;
                ack_wait   = 0;
            end
        end
    end

    // Monitor: checks accepted data against the scoreboard and the outcome at return to idle.
    initial begin
        logic       prev_req  = 1'b0;
        logic       prev_busy = 1'b0;
        logic       prev_rst  = 1'b0;
        logic [7:0] prev_data = 8'h00;
        exp_t       e;
        forever begin
            @(negedge i_clk);
            if (o_req && !prev_req) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    check_output("accept_expected", exp_q.size(), 1);
                end else begin
                    check_output("accept_data", o_data, exp_q[0].data);
                end
            end
            if (o_done) begin
                done_pulses++;
                if (!(prev_busy && !o_busy)) protocol_err++;
            end
            if (o_busy && o_ready) protocol_err++;
            if (i_reset_n && prev_rst && (o_data !== prev_data) && !(o_req && !prev_req)) protocol_err++;
            if (prev_busy && !o_busy) begin
                if (exp_q.size() == 0) begin
                    check_output("completion_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_output("done_flag", o_done, e.done);
                    check_output("timeout_flag", o_timeout, e.to);
                    check_output("ready_at_idle", o_ready, e.ready);
                    check_output("held_data", o_data, e.reset_case ? 8'h00 : e.data);
                end
            end
            prev_req  = o_req;
            prev_busy = o_busy;
            prev_rst  = i_reset_n;
            prev_data = o_data;
        end
    end

    // Safety net in case a wait somehow never ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Directed test sequence.
    initial begin
        int lat;
        int hits;
        i_reset_n     = 1'b0;
        i_valid       = 1'b0;
        i_data        = 8'h00;
        i_clr_timeout = 1'b0;
        ack_mode      = 0;

        repeat (2) @(negedge i_clk);
        check_output("rst_req", o_req, 0);
        check_output("rst_data", o_data, 8'h00);
        check_output("rst_done", o_done, 0);
        check_output("rst_timeout", o_timeout, 0);
        check_output("rst_ready", o_ready, 0);
        check_output("rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check_output("ready_after_reset", o_ready, 1);

        $display("[TB] single transfer");
        ack_mode = 2;
        apply_stimulus(8'hA5, 1, 0, 1, 0, 0);
        check_output("t1_req_high", o_req, 1);
        wait_idle("t1", 40);
        check_output("t1_ready", o_ready, 1);
        check_output("t1_timeout", o_timeout, 0);

        $display("[TB] back-to-back");
        apply_stimulus(8'h01, 1, 0, 1, 0, 1);
        apply_stimulus(8'h02, 1, 0, 1, 0, 0);
        wait_idle("t2", 40);
        check_output("t2_data", o_data, 8'h02);

        $display("[TB] timeout");
        ack_mode = 0;
        apply_stimulus(8'hC3, 0, 1, 1, 0, 0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clk);
            if (!o_req) begin
                lat = k;
                break;
            end
        end
        check_output("t3_req_cycles", lat, 16);
        check_output("t3_timeout_set", o_timeout, 1);
        @(negedge i_clk);
        check_output("t3_busy", o_busy, 0);
        check_output("t3_ready", o_ready, 1);
        i_clr_timeout = 1'b1;
        @(negedge i_clk);
        i_clr_timeout = 1'b0;
        check_output("t3_timeout_cleared", o_timeout, 0);

        $display("[TB] stale ack");
        ack_mode = 1;
        repeat (3) @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 8'h3C;
        hits    = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_ready || o_req) hits++;
        end
        check_output("t4_blocked", hits, 0);
        push_exp(8'h3C, 1, 0, 1, 0);
        ack_mode = 2;
        lat      = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (o_req) begin
                lat = k;
                break;
            end
        end
        i_valid = 1'b0;
        check_output("t4_accept_latency", lat, SYNC_FFS + 1);
        wait_idle("t4", 40);
        check_output("t4_timeout", o_timeout, 0);

        $display("[TB] timeout set with clear");
        ack_mode = 0;
        apply_stimulus(8'h5A, 0, 1, 1, 0, 0);
        repeat (15) @(negedge i_clk);
        check_output("t6_req_before", o_req, 1);
        check_output("t6_timeout_before", o_timeout, 0);
        i_clr_timeout = 1'b1;
        @(negedge i_clk);
        i_clr_timeout = 1'b0;
        check_output("t6_req_after", o_req, 0);
        check_output("t6_timeout_after", o_timeout, 1);
        wait_idle("t6", 10);
        check_output("t6_timeout_sticky", o_timeout, 1);

        $display("[TB] reset in REQ");
        apply_stimulus(8'h77, 0, 0, 0, 1, 0);
        repeat (3) @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_output("t5_req_async", o_req, 0);
        check_output("t5_busy_async", o_busy, 0);
        check_output("t5_ready_in_reset", o_ready, 0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check_output("t5_ready_after", o_ready, 1);
        check_output("t5_busy_after", o_busy, 0);
        repeat (3) @(negedge i_clk);

        check_output("total_accepts", accepts, 7);
        check_output("total_done_pulses", done_pulses, 4);
        check_output("protocol_errors", protocol_err, 0);
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
